// File: rtl/adder_tb_pkg.sv
// Shared types and constants for the adder result checker.
package adder_tb_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/result_delay_line.sv
// Fixed-depth valid/payload delay line; DEPTH=0 is a combinational pass-through.
module result_delay_line #(
  parameter int unsigned DEPTH     = 1,
  parameter int unsigned PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic                 pending
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign out_valid = in_valid & ~clear;
      assign out_data  = in_data;
      assign pending   = 1'b0;
    end else begin : g_pipe
      logic [DEPTH-1:0]     valid_q;
      logic [PAYLOAD_W-1:0] data_q [DEPTH];

      always_ff @(posedge clk) begin
        data_q[0] <= in_data;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          data_q[i] <= data_q[i-1];
        end
        if (clear) begin
          valid_q <= '0;
        end else begin
          valid_q[0] <= in_valid;
          for (int unsigned i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
          end
        end
      end

      // Valid entries still upstream of the tap; the tap itself is compared this cycle.
      always_comb begin
        pending = 1'b0;
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          pending = pending | valid_q[i];
        end
      end

      assign out_valid = valid_q[DEPTH-1];
      assign out_data  = data_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/adder_result_checker.sv
// Checks an adder's {cout,sum} against operand sums, counting and logging mismatches per run.
module adder_result_checker
  import adder_tb_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned LATENCY  = 0,
  parameter int unsigned NUM_VECS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] vec_a,
  input  logic [WIDTH-1:0] vec_b,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH:0]   first_fail_exp,
  output logic [WIDTH:0]   first_fail_got
);

  localparam int unsigned PAY_W = CNT_W + WIDTH + 1;

  state_t           state, state_next;
  logic             accept, last_vec, run_entry, dl_clear;
  logic             tap_valid, dl_pending, cmp_en, mismatch;
  logic [WIDTH:0]   exp_sum, got_sum, tap_exp;
  logic [CNT_W-1:0] tap_idx;
  logic [PAY_W-1:0] tap_data;

  assign exp_sum   = {1'b0, vec_a} + {1'b0, vec_b};
  assign got_sum   = {dut_cout, dut_sum};
  assign accept    = vec_valid & vec_ready;
  assign last_vec  = (vec_count == CNT_W'(NUM_VECS - 1));
  assign run_entry = start & ((state == ST_IDLE) | (state == ST_DONE));
  assign dl_clear  = ~reset | run_entry;

  result_delay_line #(
    .DEPTH     (LATENCY),
    .PAYLOAD_W (PAY_W)
  ) u_delay (
    .clk       (clk),
    .clear     (dl_clear),
    .in_valid  (accept),
    .in_data   ({vec_count, exp_sum}),
    .out_valid (tap_valid),
    .out_data  (tap_data),
    .pending   (dl_pending)
  );

  assign {tap_idx, tap_exp} = tap_data;
  assign cmp_en   = tap_valid & busy;
  assign mismatch = cmp_en & (got_sum != tap_exp);

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // DRAIN ends on the cycle the final tap entry is compared, so done follows the last compare.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (accept && last_vec) state_next = (LATENCY == 0) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (!dl_pending) state_next = ST_DONE;
      ST_DONE:  if (start) state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    vec_ready = (state == ST_RUN) && (vec_count < CNT_W'(NUM_VECS));
    busy      = (state == ST_RUN) || (state == ST_DRAIN);
    done      = (state == ST_DONE);
    pass      = (state == ST_DONE) && (err_count == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset || run_entry) begin
      vec_count      <= '0;
      err_count      <= '0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
      first_fail_got <= '0;
    end else begin
      if (accept) vec_count <= vec_count + 1'b1;
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (err_count == '0) begin
          first_fail_idx <= tap_idx;
          first_fail_exp <= tap_exp;
          first_fail_got <= got_sum;
        end
      end
    end
  end

endmodule
